// File: rtl/seq_shifter.sv
// Multi-cycle barrel-free shifter: shifts an N-bit operand one bit per clock
// (LSL/LSR/ASR/ROL/ROR) and reports the final value, last bit out and zero flag.
module seq_shifter #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [2:0]   mode,
    output logic [N-1:0] result,
    output logic         carry,
    output logic         zero,
    output logic         busy,
    output logic         done
);

    localparam int unsigned CW = $clog2(N + 1);
    localparam logic [N-1:0] N_VAL = N'(N);

    localparam logic [2:0] M_LSL = 3'd0;
    localparam logic [2:0] M_LSR = 3'd1;
    localparam logic [2:0] M_ASR = 3'd2;
    localparam logic [2:0] M_ROL = 3'd3;
    localparam logic [2:0] M_ROR = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    logic [N-1:0]  work;
    logic [2:0]    mode_q;
    logic [CW-1:0] cnt;

    logic [CW-1:0] k_c;
    logic [N-1:0]  shift_val_c;
    logic          shift_cy_c;

    assign result = work;

    // Step count for a new request: linear shifts saturate at N, rotates wrap.
    always_comb begin
        k_c = '0;
        case (mode)
            M_LSL, M_LSR, M_ASR: k_c = (b >= N_VAL) ? CW'(N) : CW'(b);
            M_ROL, M_ROR:        k_c = CW'(b % N_VAL);
            default:             k_c = '0;
        endcase
    end

    // One-bit step of the working register under the latched mode.
    always_comb begin
        shift_val_c = work;
        shift_cy_c  = carry;
        case (mode_q)
            M_LSL: begin
                shift_val_c = {work[N-2:0], 1'b0};
                shift_cy_c  = work[N-1];
            end
            M_LSR: begin
                shift_val_c = {1'b0, work[N-1:1]};
                shift_cy_c  = work[0];
            end
            M_ASR: begin
                shift_val_c = {work[N-1], work[N-1:1]};
                shift_cy_c  = work[0];
            end
            M_ROL: begin
                shift_val_c = {work[N-2:0], work[N-1]};
                shift_cy_c  = work[N-1];
            end
            M_ROR: begin
                shift_val_c = {work[0], work[N-1:1]};
                shift_cy_c  = work[0];
            end
            default: begin
                shift_val_c = work;
                shift_cy_c  = carry;
            end
        endcase
    end

    // Control FSM and datapath; busy/done are flopped alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            work   <= '0;
            mode_q <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            zero   <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        work   <= a;
                        mode_q <= mode;
                        cnt    <= k_c;
                        carry  <= 1'b0;
                        zero   <= (a == '0);
                        busy   <= 1'b1;
                        if (k_c != '0) begin
                            state <= SHIFT;
                            done  <= 1'b0;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    work  <= shift_val_c;
                    carry <= shift_cy_c;
                    zero  <= (shift_val_c == '0);
                    cnt   <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter (N = 8): vector table plus multi-cycle
// sequences for start-while-busy and reset abort.
module tb_seq_shifter;

    localparam int unsigned N = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   mode;
    logic [N-1:0] result;
    logic         carry;
    logic         zero;
    logic         busy;
    logic         done;

    int n_cmp;
    int n_err;

    seq_shifter #(.N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .mode   (mode),
        .result (result),
        .carry  (carry),
        .zero   (zero),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] mode;
        logic [7:0] res;
        logic       cy;
        logic       zr;
        int         k;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue one request from an IDLE cycle (called at a negedge) and check
    // busy/done every cycle through t0+k+1, the final values, and the IDLE cycle.
    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        start = 1'b1;
        a     = v.a;
        b     = v.b;
        mode  = v.mode;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = ~v.a;
        b     = v.b ^ 8'h5A;
        mode  = 3'(v.mode + 3'd1);
        for (int i = 1; i <= v.k + 1; i++) begin
            @(negedge clk);
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_done"}, 32'(done), 32'(i == v.k + 1));
        end
        check({tag, "_result"}, 32'(result), 32'(v.res));
        check({tag, "_carry"},  32'(carry),  32'(v.cy));
        check({tag, "_zero"},   32'(zero),   32'(v.zr));
        @(negedge clk);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_done"}, 32'(done), 32'd0);
        check({tag, "_hold"},      32'(result), 32'(v.res));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_cnt;
        n_cmp = 0;
        n_err = 0;

        vecs[0]  = '{8'h81, 8'd3,   3'd0, 8'h08, 1'b0, 1'b0, 3};
        vecs[1]  = '{8'h90, 8'd2,   3'd2, 8'hE4, 1'b0, 1'b0, 2};
        vecs[2]  = '{8'h80, 8'd20,  3'd2, 8'hFF, 1'b1, 1'b0, 8};
        vecs[3]  = '{8'h01, 8'd9,   3'd4, 8'h80, 1'b1, 1'b0, 1};
        vecs[4]  = '{8'hA5, 8'd8,   3'd3, 8'hA5, 1'b0, 1'b0, 0};
        vecs[5]  = '{8'h00, 8'd0,   3'd1, 8'h00, 1'b0, 1'b1, 0};
        vecs[6]  = '{8'h3C, 8'd5,   3'd6, 8'h3C, 1'b0, 1'b0, 0};
        vecs[7]  = '{8'hF0, 8'd4,   3'd1, 8'h0F, 1'b0, 1'b0, 4};
        vecs[8]  = '{8'hF0, 8'd8,   3'd1, 8'h00, 1'b1, 1'b1, 8};
        vecs[9]  = '{8'h81, 8'd3,   3'd3, 8'h0C, 1'b0, 1'b0, 3};
        vecs[10] = '{8'h81, 8'd13,  3'd4, 8'h0C, 1'b0, 1'b0, 5};
        vecs[11] = '{8'h01, 8'd255, 3'd0, 8'h00, 1'b1, 1'b1, 8};
        vecs[12] = '{8'h7F, 8'd3,   3'd2, 8'h0F, 1'b1, 1'b0, 3};
        vecs[13] = '{8'h80, 8'd1,   3'd3, 8'h01, 1'b1, 1'b0, 1};

        // Reset with start held high: start must be discarded.
        rst   = 1'b1;
        start = 1'b1;
        a     = 8'h55;
        b     = 8'd2;
        mode  = 3'd0;
        repeat (3) @(negedge clk);
        check("rst_result", 32'(result), 32'd0);
        check("rst_carry",  32'(carry),  32'd0);
        check("rst_zero",   32'(zero),   32'd1);
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_done",   32'(done),   32'd0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_done", 32'(done), 32'd0);

        for (int i = 0; i < 14; i++) begin
            run_vec(vecs[i], i);
        end

        // LSL 0xFF by 7 with start held high the whole time: one done at t0+8,
        // the queued-looking start is only taken in the following IDLE cycle.
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'd7;
        mode  = 3'd0;
        @(posedge clk);
        #1;
        a     = 8'h01;
        b     = 8'd1;
        done_cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check("hold_busy", 32'(busy), 32'd1);
            if (done) done_cnt++;
            if (i == 8) check("hold_done_t8", 32'(done), 32'd1);
        end
        check("hold_done_count", 32'(done_cnt), 32'd1);
        check("hold_result", 32'(result), 32'h80);
        check("hold_carry",  32'(carry),  32'd1);
        @(negedge clk);
        check("hold_idle_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("hold_next_busy", 32'(busy), 32'd1);
        check("hold_next_done", 32'(done), 32'd0);
        start = 1'b0;
        @(negedge clk);
        check("hold_next_done2", 32'(done),   32'd1);
        check("hold_next_res",   32'(result), 32'h02);
        check("hold_next_carry", 32'(carry),  32'd0);
        @(negedge clk);

        // LSR 0xF0 by 6 aborted by reset asserted during t0+3.
        start = 1'b1;
        a     = 8'hF0;
        b     = 8'd6;
        mode  = 3'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check("abort_busy", 32'(busy), 32'd1);
            check("abort_done", 32'(done), 32'd0);
        end
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check("abort_result", 32'(result), 32'd0);
        check("abort_zero",   32'(zero),   32'd1);
        check("abort_carry",  32'(carry),  32'd0);
        check("abort_busy0",  32'(busy),   32'd0);
        check("abort_done0",  32'(done),   32'd0);
        rst   = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_quiet_busy", 32'(busy), 32'd0);
            check("abort_quiet_done", 32'(done), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
